// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs drained round-robin onto a registered common data bus
// Ports: clk/rst/flush control; fu_done/fu_result/fu_tag/fu_robid per-FU results in (flattened, FU i at slice i);
//        fus_busy per-FU FIFO full; cdbval/cdbid/cdbrobid/cdbtransmit broadcast; overflow sticky drop flag
module cdb_arbiter #(
    parameter int FU_COUNT  = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [FU_COUNT-1:0]   fu_done,
    input  logic [FU_COUNT*8-1:0] fu_result,
    input  logic [FU_COUNT*4-1:0] fu_tag,
    input  logic [FU_COUNT*8-1:0] fu_robid,
    output logic [FU_COUNT-1:0]   fus_busy,
    output logic [7:0]            cdbval,
    output logic [3:0]            cdbid,
    output logic [7:0]            cdbrobid,
    output logic                  cdbtransmit,
    output logic                  overflow
);
    localparam int RW = FU_COUNT > 1 ? $clog2(FU_COUNT) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    logic [19:0]         mem_q [FU_COUNT][BUF_DEPTH];
    logic [CW-1:0]       cnt_q [FU_COUNT];
    logic [CW-1:0]       cnt_d [FU_COUNT];
    logic [RW-1:0]       rr_q, rr_d, win;
    logic                win_vld;
    logic [FU_COUNT-1:0] push, pop;
    logic [7:0]          cdbval_q, cdbrobid_q;
    logic [3:0]          cdbid_q;
    logic                cdbtransmit_q, overflow_q;

    function automatic logic [RW-1:0] wrap_add(logic [RW-1:0] a, int k);
        int s = int'(a) + k;
        return RW'(s >= FU_COUNT ? s - FU_COUNT : s);
    endfunction

    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        // descending scan so the lowest offset from rr_q is assigned last and wins
        for (int k = FU_COUNT - 1; k >= 0; k--)
            if (cnt_q[wrap_add(rr_q, k)] != '0) begin
                win_vld = 1'b1;
                win     = wrap_add(rr_q, k);
            end
        rr_d = (win_vld && !flush) ? wrap_add(win, 1) : rr_q;
        for (int i = 0; i < FU_COUNT; i++) begin
            fus_busy[i] = cnt_q[i] == FULL;
            push[i]     = fu_done[i] && !fus_busy[i] && !flush;
            pop[i]      = win_vld && win == RW'(i) && !flush;
            cnt_d[i]    = flush ? '0 : cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q          <= '0;
            cdbval_q      <= '0;
            cdbid_q       <= '0;
            cdbrobid_q    <= '0;
            cdbtransmit_q <= 1'b0;
            overflow_q    <= 1'b0;
            for (int i = 0; i < FU_COUNT; i++) cnt_q[i] <= '0;
        end else begin
            rr_q          <= rr_d;
            cdbtransmit_q <= win_vld && !flush;
            overflow_q    <= overflow_q | (!flush && |(fu_done & fus_busy));
            if (win_vld && !flush) {cdbval_q, cdbid_q, cdbrobid_q} <= mem_q[win][0];
            for (int i = 0; i < FU_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
                // head lives at slot 0; a pop shifts the queue down, a push lands just past the post-pop tail
                for (int j = 0; j < BUF_DEPTH; j++) begin
                    if (pop[i] && j < BUF_DEPTH - 1) mem_q[i][j] <= mem_q[i][(j + 1) % BUF_DEPTH];
                    if (push[i] && CW'(j) == cnt_q[i] - CW'(pop[i]))
                        mem_q[i][j] <= {fu_result[i*8 +: 8], fu_tag[i*4 +: 4], fu_robid[i*8 +: 8]};
                end
            end
        end
    end

    assign cdbval      = cdbval_q;
    assign cdbid       = cdbid_q;
    assign cdbrobid    = cdbrobid_q;
    assign cdbtransmit = cdbtransmit_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus random traffic against a queue-based reference model
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [7:0]  fu_done, fus_busy;
    logic [63:0] fu_result, fu_robid;
    logic [31:0] fu_tag;
    logic [7:0]  cdbval, cdbrobid;
    logic [3:0]  cdbid;
    logic        cdbtransmit, overflow;

    cdb_arbiter #(.FU_COUNT(8), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .fu_done(fu_done), .fu_result(fu_result),
        .fu_tag(fu_tag), .fu_robid(fu_robid), .fus_busy(fus_busy), .cdbval(cdbval),
        .cdbid(cdbid), .cdbrobid(cdbrobid), .cdbtransmit(cdbtransmit), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [19:0] mq [8][$];
    int          m_rr = 0;
    logic        m_tx = 1'b0, m_ovf = 1'b0;
    logic [7:0]  m_val = '0, m_rob = '0;
    logic [3:0]  m_id = '0;
    logic [7:0]  log_q [$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model();
        bit   full [8];
        int   w;
        logic [19:0] e;
        if (rst) begin
            for (int i = 0; i < 8; i++) mq[i].delete();
            m_rr = 0; m_tx = 0; m_val = 0; m_id = 0; m_rob = 0; m_ovf = 0;
        end else if (flush) begin
            for (int i = 0; i < 8; i++) mq[i].delete();
            m_tx = 0;
        end else begin
            for (int i = 0; i < 8; i++) full[i] = mq[i].size() == 2;
            w = -1;
            for (int k = 0; k < 8; k++)
                if (w < 0 && mq[(m_rr + k) % 8].size() > 0) w = (m_rr + k) % 8;
            m_tx = w >= 0;
            if (w >= 0) begin
                e = mq[w].pop_front();
                {m_val, m_id, m_rob} = e;
                m_rr = (w + 1) % 8;
            end
            for (int i = 0; i < 8; i++)
                if (fu_done[i]) begin
                    if (full[i]) m_ovf = 1;
                    else mq[i].push_back({fu_result[i*8 +: 8], fu_tag[i*4 +: 4], fu_robid[i*8 +: 8]});
                end
        end
    endtask

    task automatic step();
        logic [7:0] eb;
        @(posedge clk);
        model();
        #1;
        for (int i = 0; i < 8; i++) eb[i] = mq[i].size() == 2;
        chk("busy", 32'(fus_busy), 32'(eb));
        chk("tx", 32'(cdbtransmit), 32'(m_tx));
        chk("data", 32'({cdbval, cdbid, cdbrobid}), 32'({m_val, m_id, m_rob}));
        chk("ovf", 32'(overflow), 32'(m_ovf));
        if (cdbtransmit) log_q.push_back(cdbrobid);
    endtask

    task automatic idle();
        fu_done = '0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic set_fu(int i, logic [7:0] r, logic [3:0] t, logic [7:0] o);
        fu_done[i] = 1'b1;
        fu_result[i*8 +: 8] = r;
        fu_tag[i*4 +: 4] = t;
        fu_robid[i*8 +: 8] = o;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; step(); rst = 1'b0; log_q.delete();
    endtask

    initial begin
        idle(); fu_result = '0; fu_tag = '0; fu_robid = '0;
        do_reset();
        chk("rst_out", 32'({cdbtransmit, cdbval, cdbid, cdbrobid, overflow, fus_busy}), 32'(0));

        set_fu(3, 8'hA5, 4'h6, 8'h12); step(); idle();
        chk("single_e0", 32'(cdbtransmit), 32'(0));
        step();
        chk("single_e1", 32'({cdbtransmit, cdbval, cdbid, cdbrobid}), 32'({1'b1, 8'hA5, 4'h6, 8'h12}));
        step();
        chk("single_after", 32'(cdbtransmit), 32'(0));

        do_reset();
        for (int i = 0; i < 8; i++) if (i == 0 || i == 2 || i == 5) set_fu(i, 8'(i), 4'(i), 8'(i));
        step(); idle();
        for (int n = 0; n < 3; n++) step();
        chk("cont_n", 32'(log_q.size()), 32'(3));
        if (log_q.size() == 3) begin
            chk("cont_0", 32'(log_q[0]), 32'(0));
            chk("cont_1", 32'(log_q[1]), 32'(2));
            chk("cont_2", 32'(log_q[2]), 32'(5));
        end
        set_fu(0, 8'h00, 4'h0, 8'h00); set_fu(7, 8'h07, 4'h7, 8'h07); step(); idle(); step();
        chk("cont_rr6", 32'({cdbtransmit, cdbrobid}), 32'({1'b1, 8'h07}));
        step();
        chk("cont_rr_wrap", 32'({cdbtransmit, cdbrobid}), 32'({1'b1, 8'h00}));

        do_reset();
        set_fu(0, 8'h01, 4'h1, 8'h01); set_fu(1, 8'h11, 4'h1, 8'h11); step();
        set_fu(0, 8'h02, 4'h1, 8'h02); set_fu(1, 8'h12, 4'h1, 8'h12); step();
        chk("fill_busy", 32'(fus_busy[1]), 32'(1));
        chk("fill_noovf", 32'(overflow), 32'(0));
        idle(); set_fu(1, 8'h13, 4'h1, 8'h13); step(); idle();
        chk("fill_ovf", 32'(overflow), 32'(1));
        for (int n = 0; n < 6; n++) step();
        begin
            logic [7:0] f1 [$];
            foreach (log_q[k]) if (log_q[k][7:4] == 4'h1) f1.push_back(log_q[k]);
            chk("fill_n", 32'(f1.size()), 32'(2));
            if (f1.size() == 2) begin
                chk("fill_ord0", 32'(f1[0]), 32'h11);
                chk("fill_ord1", 32'(f1[1]), 32'h12);
            end
        end

        do_reset();
        for (int c = 0; c < 32; c++) begin
            for (int i = 0; i < 8; i++) set_fu(i, 8'($urandom), 4'($urandom), 8'(i));
            step();
        end
        idle();
        for (int n = 0; n < 20; n++) step();
        chk("fair_n", 32'(log_q.size() >= 32), 32'(1));
        for (int k = 0; k < 32 && k < log_q.size(); k++) chk("fair_grant", 32'(log_q[k]), 32'(k % 8));

        do_reset();
        for (int i = 0; i < 5; i++) set_fu(i, 8'h80, 4'h8, 8'(8'h80 + i));
        step(); idle(); flush = 1'b1; step(); flush = 1'b0;
        chk("flush_tx", 32'(cdbtransmit), 32'(0));
        chk("flush_busy", 32'(fus_busy), 32'(0));
        for (int n = 0; n < 10; n++) step();
        chk("flush_none", 32'(log_q.size()), 32'(0));

        do_reset();
        set_fu(5, 8'h55, 4'h5, 8'h55); set_fu(6, 8'h66, 4'h6, 8'h66); set_fu(7, 8'h77, 4'h7, 8'h77);
        step(); idle(); rst = 1'b1; step(); rst = 1'b0; log_q.delete();
        chk("rstmid_out", 32'({cdbtransmit, cdbval, cdbid, cdbrobid, overflow, fus_busy}), 32'(0));
        for (int n = 0; n < 5; n++) step();
        chk("rstmid_none", 32'(log_q.size()), 32'(0));

        for (int c = 0; c < 3000; c++) begin
            fu_done = 8'($urandom) & 8'($urandom);
            fu_result = {$urandom, $urandom};
            fu_tag = $urandom;
            fu_robid = {$urandom, $urandom};
            flush = $urandom_range(0, 49) == 0;
            rst = $urandom_range(0, 199) == 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
